// File: rtl/sync_timing_decoder.sv
// Receive-side sync decoder: measures incoming hsync/vsync periods, locks onto
// the stream and regenerates pixel position for capture and overlay logic.
module sync_timing_decoder #(
  parameter bit HSYNC_POLARITY_IS_POSITIVE = 1'b0,
  parameter bit VSYNC_POLARITY_IS_POSITIVE = 1'b0,
  parameter int H_VISIBLE    = 320,
  parameter int H_SYNC_START = 328,
  parameter int H_TOTAL      = 400,
  parameter int V_VISIBLE    = 480,
  parameter int V_SYNC_START = 490,
  parameter int V_TOTAL      = 525,
  parameter int LOCK_LINES   = 4
) (
  input  logic        clkPixel,
  input  logic        resetN,
  input  logic        hsyncIn,
  input  logic        vsyncIn,
  output logic        locked,
  output logic        videoActive,
  output logic [9:0]  hPos,
  output logic [9:0]  vPos,
  output logic        frameStart,
  output logic        syncError,
  output logic [10:0] lineLength,
  output logic [9:0]  frameLines
);

  // state  | meaning
  // SEARCH | measuring line periods, counting consecutive good ones
  // HLOCK  | line period trusted, confirming lines per frame
  // LOCKED | frame structure confirmed, positions valid
  typedef enum logic [1:0] {SEARCH, HLOCK, LOCKED} stateT;

  localparam logic        H_ASSERT   = HSYNC_POLARITY_IS_POSITIVE;
  localparam logic        V_ASSERT   = VSYNC_POLARITY_IS_POSITIVE;
  localparam logic [10:0] H_TOTAL_W  = 11'(H_TOTAL);
  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_LOAD     = 11'(H_SYNC_START + 1);
  localparam logic [10:0] H_VIS_W    = 11'(H_VISIBLE);
  localparam logic [10:0] H_TIMEOUT  = 11'(2 * H_TOTAL);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_LOAD     = 10'(V_SYNC_START);
  localparam logic [9:0]  V_VIS_W    = 10'(V_VISIBLE);
  localparam logic [10:0] V_TOTAL_W  = 11'(V_TOTAL);
  localparam logic [10:0] V_TIMEOUT  = 11'(2 * V_TOTAL);
  localparam logic [7:0]  GOOD_LINES = 8'(LOCK_LINES);

  stateT       state, stateNext;
  logic        hPrev, vPrev;
  logic        hEdge, vEdge;
  logic [10:0] hCount;
  logic [9:0]  vCount;
  logic [10:0] hPeriod;
  logic [10:0] lineCnt;
  logic [7:0]  goodCnt;
  logic        hValid, vSeen;
  logic        periodGood, periodBad, timeout, enterSearch, hWrap;

  assign hEdge      = (hsyncIn == H_ASSERT) && (hPrev != H_ASSERT);
  assign vEdge      = (vsyncIn == V_ASSERT) && (vPrev != V_ASSERT);
  assign periodGood = hEdge && hValid && (hPeriod == H_TOTAL_W);
  assign periodBad  = hEdge && hValid && (hPeriod != H_TOTAL_W);
  assign timeout    = (hPeriod == H_TIMEOUT) || (lineCnt == V_TIMEOUT);
  assign hWrap      = !hEdge && (hCount == H_LAST);

  always_comb begin
    stateNext = state;
    unique case (state)
      SEARCH: if (goodCnt == GOOD_LINES) stateNext = HLOCK;
      HLOCK: begin
        if (periodBad) stateNext = SEARCH;
        else if (vEdge && vSeen) stateNext = (lineCnt == V_TOTAL_W) ? LOCKED : SEARCH;
      end
      LOCKED: if (periodBad || (vEdge && lineCnt != V_TOTAL_W)) stateNext = SEARCH;
      default: stateNext = SEARCH;
    endcase
    if (timeout) stateNext = SEARCH;
  end

  // A timeout while already searching restarts acquisition as well.
  assign enterSearch = (stateNext == SEARCH) && ((state != SEARCH) || timeout);

  always_ff @(posedge clkPixel or negedge resetN) begin
    if (!resetN) begin
      state      <= SEARCH;
      hPrev      <= H_ASSERT;
      vPrev      <= V_ASSERT;
      hCount     <= '0;
      vCount     <= '0;
      hPeriod    <= '0;
      lineCnt    <= '0;
      goodCnt    <= '0;
      hValid     <= 1'b0;
      vSeen      <= 1'b0;
      syncError  <= 1'b0;
      lineLength <= '0;
      frameLines <= '0;
    end else begin
      state     <= stateNext;
      hPrev     <= hsyncIn;
      vPrev     <= vsyncIn;
      syncError <= (state == LOCKED) && (stateNext == SEARCH);

      if (hEdge) hCount <= H_LOAD;
      else if (hCount == H_LAST) hCount <= '0;
      else hCount <= hCount + 11'd1;

      if (vEdge) vCount <= V_LOAD;
      else if (hWrap) vCount <= (vCount == V_LAST) ? 10'd0 : vCount + 10'd1;

      if (hEdge) begin
        hPeriod    <= 11'd1;
        lineLength <= hPeriod;
      end else if (hPeriod != 11'h7FF) begin
        hPeriod <= hPeriod + 11'd1;
      end

      if (vEdge) lineCnt <= '0;
      else if (hEdge && lineCnt != 11'h7FF) lineCnt <= lineCnt + 11'd1;

      if (vEdge && vSeen) frameLines <= (lineCnt > 11'd1023) ? 10'h3FF : lineCnt[9:0];

      if (enterSearch) goodCnt <= '0;
      else if (state == SEARCH && hEdge && hValid)
        goodCnt <= !periodGood ? 8'd0 : (goodCnt == GOOD_LINES) ? goodCnt : goodCnt + 8'd1;

      if (enterSearch) hValid <= 1'b0;
      else if (hEdge) hValid <= 1'b1;

      if (enterSearch) vSeen <= 1'b0;
      else if (vEdge) vSeen <= 1'b1;
    end
  end

  assign locked      = (state == LOCKED);
  assign videoActive = locked && (hCount < H_VIS_W) && (vCount < V_VIS_W);
  assign hPos        = videoActive ? hCount[9:0] : 10'd0;
  assign vPos        = videoActive ? {1'b0, vCount[9:1]} : 10'd0;
  assign frameStart  = locked && (hCount == 11'd0) && (vCount == 10'd0);

endmodule

// File: tb/tb_sync_timing_decoder.sv
// Bench for sync_timing_decoder: a scaled-down timing generator drives two
// decoders (negative and positive hsync polarity) against a queued expectation.
module tb_sync_timing_decoder;

  localparam int HV = 16, HS = 20, HT = 24;
  localparam int VV = 12, VS = 14, VT = 18;

  logic        clkPixel = 1'b0;
  logic        resetN   = 1'b0;
  logic        hsyncIn  = 1'b1;
  logic        vsyncIn  = 1'b1;
  logic        hsyncInPos;
  assign hsyncInPos = ~hsyncIn;

  logic        locked, videoActive, frameStart, syncError;
  logic [9:0]  hPos, vPos, frameLines;
  logic [10:0] lineLength;
  logic        lockedP, videoActiveP, frameStartP, syncErrorP;
  logic [9:0]  hPosP, vPosP, frameLinesP;
  logic [10:0] lineLengthP;

  sync_timing_decoder #(
    .HSYNC_POLARITY_IS_POSITIVE(1'b0), .VSYNC_POLARITY_IS_POSITIVE(1'b0),
    .H_VISIBLE(HV), .H_SYNC_START(HS), .H_TOTAL(HT),
    .V_VISIBLE(VV), .V_SYNC_START(VS), .V_TOTAL(VT), .LOCK_LINES(4)
  ) dut (
    .clkPixel(clkPixel), .resetN(resetN), .hsyncIn(hsyncIn), .vsyncIn(vsyncIn),
    .locked(locked), .videoActive(videoActive), .hPos(hPos), .vPos(vPos),
    .frameStart(frameStart), .syncError(syncError),
    .lineLength(lineLength), .frameLines(frameLines)
  );

  sync_timing_decoder #(
    .HSYNC_POLARITY_IS_POSITIVE(1'b1), .VSYNC_POLARITY_IS_POSITIVE(1'b0),
    .H_VISIBLE(HV), .H_SYNC_START(HS), .H_TOTAL(HT),
    .V_VISIBLE(VV), .V_SYNC_START(VS), .V_TOTAL(VT), .LOCK_LINES(4)
  ) dutPos (
    .clkPixel(clkPixel), .resetN(resetN), .hsyncIn(hsyncInPos), .vsyncIn(vsyncIn),
    .locked(lockedP), .videoActive(videoActiveP), .hPos(hPosP), .vPos(vPosP),
    .frameStart(frameStartP), .syncError(syncErrorP),
    .lineLength(lineLengthP), .frameLines(frameLinesP)
  );

  always #5 clkPixel = ~clkPixel;

  int nCompared   = 0;
  int nMismatched = 0;

  task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Generator position presented in the current cycle.
  int gh = HT - 1, gv = VT - 1, frameNo = -1;
  int lineLenCur = HT, vTotalCur = VT;
  bit hsyncKill = 1'b0, expLocked = 1'b0, expSyncErr = 1'b0, chkEn = 1'b1;
  logic [24:0] sbQ[$];

  task automatic tick(input bit doReset);
    bit vis;
    logic [23:0] e;
    @(posedge clkPixel);
    #1;
    gh++;
    if (gh >= lineLenCur) begin
      gh = 0;
      gv++;
      if (gv >= vTotalCur) begin
        gv = 0;
        frameNo++;
      end
    end
    hsyncIn = hsyncKill || !(gh >= HS && gh < HS + 3);
    vsyncIn = !(gv == VS || gv == VS + 1);
    if (doReset) begin
      #1 resetN = 1'b0;
      #1;
      checkEq("asyncReset", {locked, videoActive, hPos, vPos, frameStart, syncError, lineLength, frameLines}, 64'd0);
      checkEq("asyncResetPos", {lockedP, videoActiveP, hPosP, vPosP, frameStartP, syncErrorP, lineLengthP, frameLinesP}, 64'd0);
    end
    vis = expLocked && gh < HV && gv < VV;
    e = {expLocked, vis, vis ? 10'(gh) : 10'd0, vis ? 10'(gv / 2) : 10'd0,
         expLocked && gh == 0 && gv == 0, expSyncErr};
    sbQ.push_back({chkEn, e});
  endtask

  task automatic advanceTo(input int f, input int v, input int h);
    int n = 0;
    while (!(frameNo == f && gv == v && gh == h) && n < 3000) begin
      tick(1'b0);
      n++;
    end
    if (n >= 3000) checkEq("advanceBound", {8'(frameNo), 8'(gv), 8'(gh)}, {8'(f), 8'(v), 8'(h)});
  endtask

  always @(negedge clkPixel) begin
    logic [24:0] e;
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      if (e[24]) begin
        checkEq("outs", {locked, videoActive, hPos, vPos, frameStart, syncError}, e[23:0]);
        checkEq("outsPos", {lockedP, videoActiveP, hPosP, vPosP, frameStartP, syncErrorP}, e[23:0]);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clkPixel);
    @(negedge clkPixel);
    checkEq("resetState", {locked, videoActive, hPos, vPos, frameStart, syncError, lineLength, frameLines}, 64'd0);
    resetN = 1'b1;

    // Clean stream: HLOCK after line 4, locks at the second vsync edge.
    advanceTo(1, VS, 0);
    expLocked = 1'b1;
    advanceTo(1, VS + 1, 0);
    checkEq("frameLinesClean", frameLines, 18);
    checkEq("frameLinesCleanPos", frameLinesP, 18);
    checkEq("lineLenClean", lineLength, HT);
    advanceTo(2, 3, 23);

    // One 25-clock line while locked.
    lineLenCur = HT + 1;
    chkEn = 1'b0;
    tick(1'b0);
    lineLenCur = HT;
    advanceTo(2, 4, HS);
    chkEn = 1'b1;
    expLocked = 1'b0;
    expSyncErr = 1'b1;
    tick(1'b0);
    expSyncErr = 1'b0;
    checkEq("lineLenLong", lineLength, HT + 1);
    checkEq("lineLenLongPos", lineLengthP, HT + 1);
    advanceTo(3, VS, 0);
    expLocked = 1'b1;

    // hsync stuck deasserted: timeout 48 clocks after the last edge.
    advanceTo(4, 2, 0);
    hsyncKill = 1'b1;
    advanceTo(4, 3, HS);
    expLocked = 1'b0;
    expSyncErr = 1'b1;
    tick(1'b0);
    expSyncErr = 1'b0;
    checkEq("lineLenKept", lineLength, HT);
    checkEq("lineLenKeptPos", lineLengthP, HT);
    advanceTo(4, 5, 0);
    hsyncKill = 1'b0;
    advanceTo(5, VS, 0);
    expLocked = 1'b1;

    // Short frame of 17 lines.
    vTotalCur = VT - 1;
    advanceTo(5, VT - 2, HT - 1);
    chkEn = 1'b0;
    tick(1'b0);
    vTotalCur = VT;
    advanceTo(6, VS, 0);
    chkEn = 1'b1;
    expLocked = 1'b0;
    expSyncErr = 1'b1;
    tick(1'b0);
    expSyncErr = 1'b0;
    checkEq("frameLinesShort", frameLines, VT - 1);
    checkEq("frameLinesShortPos", frameLinesP, VT - 1);
    advanceTo(8, VS, 0);
    expLocked = 1'b1;

    // Mid-line reset, held until both syncs are asserted, released there.
    advanceTo(9, 5, 6);
    expLocked = 1'b0;
    tick(1'b1);
    advanceTo(10, VS, HS + 1);
    resetN = 1'b1;
    advanceTo(10, VS + 1, HS + 1);
    checkEq("lineLenAfterRst", lineLength, 23);
    checkEq("lineLenAfterRstPos", lineLengthP, 23);
    advanceTo(11, VS, 1);
    checkEq("frameLinesNoPhantom", frameLines, 0);
    checkEq("frameLinesNoPhantomPos", frameLinesP, 0);
    advanceTo(12, VS, 0);
    expLocked = 1'b1;
    advanceTo(12, VS + 2, 0);
    checkEq("frameLinesRelock", frameLines, VT);
    advanceTo(13, 1, 0);

    @(negedge clkPixel);
    @(posedge clkPixel);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/sync_timing_decoder.md
# sync_timing_decoder

Receive-side counterpart of the pixel timing generator. Samples an incoming hsync/vsync pair in the clkPixel domain and measures line and frame periods. Locks onto the stream and regenerates hPos/vPos/videoActive so capture and overlay logic can address pixels of an externally timed 320x480 (line-doubled to 240) stream. It sits directly behind the sync inputs and feeds capture/line-buffer writers.

## Interface
- HSYNC_POLARITY_IS_POSITIVE, 0, asserted level of hsyncIn
- VSYNC_POLARITY_IS_POSITIVE, 0, asserted level of vsyncIn
- H_VISIBLE, 320, active pixels per line
- H_SYNC_START, 328, horizontal position of first hsync-asserted pixel
- H_TOTAL, 400, clocks per line
- V_VISIBLE, 480, active lines per frame
- V_SYNC_START, 490, line number of first vsync-asserted line
- V_TOTAL, 525, lines per frame
- LOCK_LINES, 4, consecutive good line periods needed to leave SEARCH
- clkPixel  in  1  pixel clock. One clock; reset is asynchronous and active-low.
- resetN  in  1  asynchronous active-low reset
- hsyncIn  in  1  horizontal sync, synchronous to clkPixel
- vsyncIn  in  1  vertical sync, synchronous to clkPixel
- locked  out  1  high in LOCKED state
- videoActive  out  1  locked & hCount<H_VISIBLE & vCount<V_VISIBLE
- hPos  out  10  hCount[9:0] when videoActive, else 0
- vPos  out  10  {1'b0, vCount[9:1]} when videoActive, else 0
- frameStart  out  1  one-cycle pulse when locked, hCount==0, vCount==0
- syncError  out  1  one-cycle pulse on any lock loss
- lineLength  out  11  last measured hsync period, saturating at 2047
- frameLines  out  10  last measured hsync-edge count between vsync edges, saturating at 1023

## Operation
- Edge detect: hPrev/vPrev hold last sample. hEdge = hsyncIn asserted & hPrev deasserted; vEdge likewise. Reset loads hPrev/vPrev to the *asserted* level, so a sync held asserted through reset release creates no edge.
- hCount (11 b):
  - On hEdge, load H_SYNC_START+1.
  - Otherwise, wrap H_TOTAL-1 -> 0, else increment.
- vCount (10 b):
  - On vEdge, load V_SYNC_START.
  - Else, on hCount wrap: V_TOTAL-1 -> 0, else increment.
  - vEdge wins over a coincident wrap.
- hPeriod counter: set to 1 on hEdge, else saturating increment. At hEdge, lineLength <= hPeriod. The sample is good if it equals H_TOTAL.
- lineCnt: cleared on vEdge, incremented on hEdge, saturating. At vEdge, frameLines <= lineCnt if vSeen. vSeen is set on vEdge and cleared on entering SEARCH.
- FSM:
  - SEARCH: goodCnt counts consecutive good periods; a bad period clears it. goodCnt==LOCK_LINES -> HLOCK.
  - HLOCK: bad period -> SEARCH. vEdge with vSeen and lineCnt==V_TOTAL -> LOCKED. vEdge with vSeen and lineCnt!=V_TOTAL -> SEARCH.
  - LOCKED: bad period, or vEdge with lineCnt!=V_TOTAL -> SEARCH with syncError.
- Timeouts, from any state -> SEARCH:
  - hPeriod reaches 2*H_TOTAL.
  - lineCnt reaches 2*V_TOTAL.
  - syncError pulses only if the state was LOCKED.
- The first hEdge after reset or SEARCH entry has no valid period and is ignored for goodCnt.

## Timing
- Reset values: locked 0, videoActive 0, hPos 0, vPos 0, frameStart 0, syncError 0, lineLength 0, frameLines 0. hCount 0, vCount 0, state SEARCH, goodCnt 0, vSeen 0, hPeriod 0, lineCnt 0.
- Position latency: for a stream driven by a generator with the same parameters on the same clock, hCount/vCount equal the generator's counters in the cycle after the first hEdge/vEdge. There is zero lag thereafter.
- Outputs are combinational from registered state. locked/syncError change on the edge that changes state.
- Lock time from a clean stream: LOCK_LINES+1 hEdges to reach HLOCK, then two vEdges after vSeen is cleared. Worst case is under 2 frames plus 5 lines.
- Reset mid-frame: all state is cleared immediately, and reacquisition starts from scratch.

## Test plan
- Clean stream (400 clk lines, hsync low 328..375, 525 lines, vsync low lines 490..491) -> HLOCK after 5th hEdge. locked rises at the second counted vEdge. hPos/vPos match the generator cycle-for-cycle. frameStart fires once per 210000 clocks.
- While locked, one line of 401 clocks -> syncError pulse at that hEdge, locked 0, lineLength 401. Relock within 2 frames.
- hsync held deasserted while locked -> at hPeriod==800: syncError, locked 0. lineLength keeps its last value.
- Frame of 524 lines while locked -> at vEdge: frameLines 524, syncError, SEARCH.
- Sync asserted across reset release -> no hEdge/vEdge until the next deassert/assert. resetN pulsed mid-line clears all outputs to 0 asynchronously.
- HSYNC_POLARITY_IS_POSITIVE=1 with an inverted hsync stream -> same lock time and positions as the clean case.
